spi_tx_arbiter: RTL

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_defs.sv | 22 ++
 rtl/spi_tx_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/spi_tx_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/spi_defs.sv
// Shared SPI definitions: word width, frame-timing defaults and the arbiter FSM encoding.
// Used by the SPI master, the SPI slave and the transmit arbiter.
package spi_defs;

  localparam int DATA_W_DEF     = 16;
  localparam int GAP_CYCLES_DEF = 4;
  localparam int START_TO_DEF   = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

  // Counter width that can hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Requester / SPI-master side signals of the transmit arbiter, plus FSM debug taps.
// Handshake: a requester holds i_req and its word until o_ack; o_start/o_done/o_err are one-cycle strobes.
interface spi_tx_arbiter_if
  import spi_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_ack;
  logic [DATA_W-1:0]         o_send_data;
  logic                      o_start;
  logic                      i_busy;
  logic                      o_done;
  logic                      o_err;
  logic                      o_idle;
  state_e                    dbg_state;
  logic [PTR_W-1:0]          dbg_ptr;

  modport master (
    input  i_req, i_req_data, i_busy,
    output o_ack, o_send_data, o_start, o_done, o_err, o_idle, dbg_state, dbg_ptr
  );

  modport slave (
    output i_req, i_req_data, i_busy,
    input  o_ack, o_send_data, o_start, o_done, o_err, o_idle, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set req bit after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // ptr itself is visited last, so the previous winner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI master: picks a requester, strobes o_start/o_ack,
// tracks the frame via i_busy, times out a master that never starts, and enforces an idle gap.
module spi_tx_arbiter
  import spi_defs::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int START_TO   = START_TO_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  spi_tx_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = cnt_w(START_TO);
  localparam int GAP_W = cnt_w(GAP_CYCLES);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;

  rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_rr_arbiter (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_idx  = PTR_W'(i);
        win_data = bus.i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      data_q  <= '0;
      timer_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
    end
  end

  // Counters default to zero, so they restart on every state entry and only count while held.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    timer_d     = '0;
    gap_d       = '0;
    bus.o_start = 1'b0;
    bus.o_ack   = '0;
    bus.o_done  = 1'b0;
    bus.o_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          state_d = ST_START;
          ptr_d   = win_idx;
          data_d  = win_data;
        end
      end
      ST_START: begin
        bus.o_start = 1'b1;
        bus.o_ack   = NUM_REQ'(1) << ptr_q;
        state_d     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.i_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TMR_W'(START_TO - 1)) begin
          bus.o_err = 1'b1;
          state_d   = ST_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_busy) begin
          bus.o_done = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_send_data = data_q;
  assign bus.o_idle      = (state_q == ST_IDLE);
  assign bus.dbg_state   = state_q;
  assign bus.dbg_ptr     = ptr_q;

endmodule
